// File: rtl/axis_udp_pkg.sv
// ---------------------------------------------------------------------------
// axis_udp_pkg
// Shared definitions for the UDP TX/RX AXI-Stream blocks.
//   arb_state_t  : packet arbiter state (IDLE waiting for a winner, XFER
//                  streaming the rest of the owner's packet)
//   TLAST_BIT    : bit position of tlast inside one FIFO word
//   TKEEP_LSB    : first tkeep bit inside one FIFO word
//   tdata_lsb()  : first tdata bit inside one FIFO word (after tkeep)
//   src_width()  : total width of one {tdata, tkeep, tlast} FIFO word
//   clog2()      : ceil(log2(value)) for parameter arithmetic
//   idx_width()  : width needed to index n items, never less than 1
// ---------------------------------------------------------------------------
package axis_udp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int TLAST_BIT = 0;
  localparam int TKEEP_LSB = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  function automatic int tdata_lsb(input int keep_width);
    return 1 + keep_width;
  endfunction

  function automatic int src_width(input int data_width, input int keep_width);
    return data_width + keep_width + 1;
  endfunction

endpackage

// File: rtl/fwft_pkt_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Scans req starting one past
// rr_ptr and wrapping modulo N; the first set bit wins.
//   req    in  N      request vector
//   rr_ptr in  IDX_W  index of the previously served requester
//   winner out IDX_W  index of the chosen requester (0 when none)
//   valid  out 1      at least one request was set
// Shared with the RX demux scheduler, so it carries no arbiter state.
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] idx;

  // Walk the requesters in priority order (rr_ptr+1 first, rr_ptr last) and
  // latch the first one found; later hits are ignored once valid is set.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % N);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fwft_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fwft_pkt_rr_arbiter
// Packet-granular round-robin arbiter sharing one AXI-Stream master between
// NUM_SRC first-word-fall-through FIFOs of {tdata, tkeep, tlast} words.
// A grant is held until the owner's tlast word is popped, so packets never
// interleave. One output register stage; no bubbles between packets while
// TREADY stays high and some source has data.
//   CLK, RST       clock and synchronous active-high reset
//   SRC_EMPTY      per-FIFO empty (low: the SRC_DO slice is valid)
//   SRC_DO         packed FIFO words, source i at slice i
//   SRC_RDEN       per-FIFO pop, at most one bit set
//   SRC_ENABLE     per-source enable, looked at only when arbitrating
//   M_AXIS_*       registered AXI-Stream master; TID is the source index
//   GRANT          one-hot owner of the packet in flight, zero when IDLE
//   BUSY           a multi-beat packet is in flight
// ---------------------------------------------------------------------------
module fwft_pkt_rr_arbiter
  import axis_udp_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 3
) (
  input  logic                                            CLK,
  input  logic                                            RST,
  input  logic [NUM_SRC-1:0]                              SRC_EMPTY,
  input  logic [NUM_SRC*(DATA_WIDTH+KEEP_WIDTH+1)-1:0]    SRC_DO,
  output logic [NUM_SRC-1:0]                              SRC_RDEN,
  input  logic [NUM_SRC-1:0]                              SRC_ENABLE,
  output logic [DATA_WIDTH-1:0]                           M_AXIS_TDATA,
  output logic [KEEP_WIDTH-1:0]                           M_AXIS_TKEEP,
  output logic                                            M_AXIS_TLAST,
  output logic [ID_WIDTH-1:0]                             M_AXIS_TID,
  output logic                                            M_AXIS_TVALID,
  input  logic                                            M_AXIS_TREADY,
  output logic [NUM_SRC-1:0]                              GRANT,
  output logic                                            BUSY
);

  localparam int SRC_W    = src_width(DATA_WIDTH, KEEP_WIDTH);
  localparam int DATA_LSB = tdata_lsb(KEEP_WIDTH);
  localparam int IDX_W    = idx_width(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [SRC_W-1:0] src_beat [NUM_SRC];
  logic [SRC_W-1:0] sel_beat;
  logic [NUM_SRC-1:0] eligible;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             free;
  logic             pop;
  logic             pop_last;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_beat[i] = SRC_DO[i*SRC_W +: SRC_W];
  end

  assign eligible = ~SRC_EMPTY & SRC_ENABLE;
  assign free     = !M_AXIS_TVALID || M_AXIS_TREADY;

  rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (eligible),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // State register. rr_ptr doubles as the owner index while in XFER, since
  // the owner is always the most recently granted source.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pop decision. In IDLE the picker's winner is popped in the
  // same cycle it is found; in XFER only the owner may pop. A pop needs the
  // output register to be free, and nothing is popped while reset is held so
  // the FIFOs see no stray read during the reset cycle.
  always_comb begin
    state_next = state;
    sel_idx    = rr_ptr;
    pop        = 1'b0;
    SRC_RDEN   = '0;
    case (state)
      IDLE: begin
        sel_idx = pick_idx;
        pop     = pick_valid && free && !RST;
      end
      XFER: begin
        sel_idx = rr_ptr;
        pop     = !SRC_EMPTY[rr_ptr] && free && !RST;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    sel_beat = src_beat[sel_idx];
    pop_last = sel_beat[TLAST_BIT];
    if (pop) begin
      SRC_RDEN[sel_idx] = 1'b1;
      if (state == IDLE && !pop_last) begin
        state_next = XFER;
      end else if (state == XFER && pop_last) begin
        state_next = IDLE;
      end
    end
  end

  // Round-robin pointer and output register. A single-beat packet still
  // moves the pointer even though the FSM stays in IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr        <= LAST_IDX;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TID    <= '0;
    end else begin
      if (pop && state == IDLE) begin
        rr_ptr <= sel_idx;
      end
      if (pop) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= sel_beat[DATA_LSB +: DATA_WIDTH];
        M_AXIS_TKEEP  <= sel_beat[TKEEP_LSB +: KEEP_WIDTH];
        M_AXIS_TLAST  <= pop_last;
        M_AXIS_TID    <= ID_WIDTH'(sel_idx);
      end else if (M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end
    end
  end

  // GRANT and BUSY follow the state directly; IDLE never shows an owner.
  always_comb begin
    GRANT = '0;
    if (state == XFER) begin
      GRANT[rr_ptr] = 1'b1;
    end
    BUSY = (state == XFER);
  end

endmodule

// File: tb/tb_fwft_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fwft_pkt_rr_arbiter
// Self-checking bench. The bench owns the source FIFOs (arrays with head and
// tail counters), a packet-level reference model that predicts every output
// each cycle, directed scenarios with literal expectations, and a random
// phase with beat-by-beat pushes, random TREADY and random SRC_ENABLE.
// ---------------------------------------------------------------------------
module tb_fwft_pkt_rr_arbiter;

  localparam int NUM_SRC = 4;
  localparam int DW      = 32;
  localparam int KW      = DW / 8;
  localparam int IDW     = 3;
  localparam int SRC_W   = DW + KW + 1;
  localparam int DEPTH   = 64;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b1;
  logic [NUM_SRC-1:0]       SRC_EMPTY;
  logic [NUM_SRC*SRC_W-1:0] SRC_DO;
  logic [NUM_SRC-1:0]       SRC_RDEN;
  logic [NUM_SRC-1:0]       SRC_ENABLE = '1;
  logic [DW-1:0]            M_AXIS_TDATA;
  logic [KW-1:0]            M_AXIS_TKEEP;
  logic                     M_AXIS_TLAST;
  logic [IDW-1:0]           M_AXIS_TID;
  logic                     M_AXIS_TVALID;
  logic                     M_AXIS_TREADY = 1'b0;
  logic [NUM_SRC-1:0]       GRANT;
  logic                     BUSY;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [SRC_W-1:0] mem [NUM_SRC][DEPTH];
  int head [NUM_SRC] = '{default: 0};
  int tail [NUM_SRC] = '{default: 0};
  int rem  [NUM_SRC] = '{default: 0};

  int               m_owner  = -1;
  int               m_last   = NUM_SRC - 1;
  logic             m_tvalid = 1'b0;
  logic [DW-1:0]    m_data   = '0;
  logic [KW-1:0]    m_keep   = '0;
  logic             m_tlast  = 1'b0;
  int               m_tid    = 0;
  int               m_pick;
  logic             m_free;
  logic [SRC_W-1:0] m_beat;
  logic [NUM_SRC-1:0] exp_rden;
  logic [NUM_SRC-1:0] exp_grant;
  int               pend_pop = -1;
  int               pop_s;
  bit               rst_s;

  logic [DW-1:0] acc_data [16];
  int            acc_tid  [16];
  int            acc_n;
  int            rden_cnt;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  always #5 CLK = ~CLK;

  fwft_pkt_rr_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .ID_WIDTH   (IDW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SRC_EMPTY     (SRC_EMPTY),
    .SRC_DO        (SRC_DO),
    .SRC_RDEN      (SRC_RDEN),
    .SRC_ENABLE    (SRC_ENABLE),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TID    (M_AXIS_TID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .GRANT         (GRANT),
    .BUSY          (BUSY)
  );

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    assign SRC_EMPTY[g]              = (head[g] == tail[g]);
    assign SRC_DO[g*SRC_W +: SRC_W]  = mem[g][head[g] % DEPTH];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy);
    @(posedge CLK);
    #2;
    M_AXIS_TREADY = rdy;
  endtask

  task automatic sampleNeg();
    @(negedge CLK);
  endtask

  task automatic pushBeat(input int s, input logic [DW-1:0] data,
                          input logic [KW-1:0] keep, input logic last);
    mem[s][tail[s] % DEPTH] = {data, keep, last};
    tail[s]++;
  endtask

  task automatic pushPkt(input int s, input int len, input logic [DW-1:0] base);
    for (int j = 0; j < len; j++) begin
      pushBeat(s, base + DW'(j), '1, j == len - 1);
    end
  endtask

  task automatic doReset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  task automatic observe();
    if (M_AXIS_TVALID && M_AXIS_TREADY && acc_n < 16) begin
      acc_data[acc_n] = M_AXIS_TDATA;
      acc_tid[acc_n]  = int'(M_AXIS_TID);
      acc_n++;
    end
  endtask

  // FIFO side of the bench: apply the pop the model decided on, or flush all
  // FIFOs when reset was sampled (they share the arbiter's reset).
  always @(posedge CLK) begin
    rst_s = RST;
    pop_s = pend_pop;
    #1;
    if (rst_s) begin
      for (int i = 0; i < NUM_SRC; i++) head[i] = tail[i];
    end else if (pop_s >= 0) begin
      head[pop_s]++;
    end
  end

  // Packet-level reference model and per-cycle comparison. m_owner is the
  // source whose packet is in flight (-1 when none), m_last the source that
  // was served most recently, m_* the word sitting in the output register.
  always @(negedge CLK) begin
    m_free = !m_tvalid || M_AXIS_TREADY;
    m_pick = -1;
    if (!RST && m_free) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          if (m_pick < 0 && head[(m_last + k) % NUM_SRC] != tail[(m_last + k) % NUM_SRC]
              && SRC_ENABLE[(m_last + k) % NUM_SRC]) begin
            m_pick = (m_last + k) % NUM_SRC;
          end
        end
      end else if (head[m_owner] != tail[m_owner]) begin
        m_pick = m_owner;
      end
    end
    exp_rden = '0;
    if (m_pick >= 0) exp_rden[m_pick] = 1'b1;
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;

    checkOutput("model_rden",   64'(SRC_RDEN),      64'(exp_rden));
    checkOutput("model_grant",  64'(GRANT),         64'(exp_grant));
    checkOutput("model_busy",   64'(BUSY),          64'(m_owner >= 0));
    checkOutput("model_tvalid", 64'(M_AXIS_TVALID), 64'(m_tvalid));
    checkOutput("model_tdata",  64'(M_AXIS_TDATA),  64'(m_data));
    checkOutput("model_tkeep",  64'(M_AXIS_TKEEP),  64'(m_keep));
    checkOutput("model_tlast",  64'(M_AXIS_TLAST),  64'(m_tlast));
    checkOutput("model_tid",    64'(M_AXIS_TID),    64'(m_tid));

    if (RST) begin
      m_owner  = -1;
      m_last   = NUM_SRC - 1;
      m_tvalid = 1'b0;
      m_data   = '0;
      m_keep   = '0;
      m_tlast  = 1'b0;
      m_tid    = 0;
    end else if (m_pick >= 0) begin
      m_beat = mem[m_pick][head[m_pick] % DEPTH];
      {m_data, m_keep, m_tlast} = m_beat;
      m_tid    = m_pick;
      m_tvalid = 1'b1;
      if (m_owner < 0) begin
        m_last = m_pick;
        if (!m_tlast) m_owner = m_pick;
      end else if (m_tlast) begin
        m_owner = -1;
      end
    end else if (M_AXIS_TREADY) begin
      m_tvalid = 1'b0;
    end
    pend_pop = m_pick;
  end

  logic [0:8] rdy_pat;

  initial begin
    // Reset state
    sampleNeg();
    checkOutput("reset_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("reset_grant",  64'(GRANT),         64'd0);
    checkOutput("reset_busy",   64'(BUSY),          64'd0);
    checkOutput("reset_tdata",  64'(M_AXIS_TDATA),  64'd0);

    // Single 4-beat packet from source 0
    doReset();
    M_AXIS_TREADY = 1'b1;
    pushPkt(0, 4, 32'h10);
    sampleNeg();
    checkOutput("t1_pre_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("t1_pre_rden",   64'(SRC_RDEN),      64'b0001);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1);
      sampleNeg();
      checkOutput("t1_tvalid", 64'(M_AXIS_TVALID), 64'd1);
      checkOutput("t1_tdata",  64'(M_AXIS_TDATA),  64'h10 + 64'(j));
      checkOutput("t1_tid",    64'(M_AXIS_TID),    64'd0);
      checkOutput("t1_grant",  64'(GRANT),         (j < 3) ? 64'b0001 : 64'b0000);
    end
    applyStimulus(1'b1);
    sampleNeg();
    checkOutput("t1_post_tvalid", 64'(M_AXIS_TVALID), 64'd0);

    // Four sources, two 2-beat packets each: strict 0,1,2,3 rotation, no bubble
    doReset();
    M_AXIS_TREADY = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int p = 0; p < 2; p++) pushPkt(s, 2, DW'(32'h100 * s + 16 * p));
    end
    sampleNeg();
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1);
      sampleNeg();
      checkOutput("t2_tvalid", 64'(M_AXIS_TVALID), 64'd1);
      checkOutput("t2_tid",    64'(M_AXIS_TID),    64'((n / 2) % 4));
      checkOutput("t2_tdata",  64'(M_AXIS_TDATA),
                  64'(32'h100 * ((n / 2) % 4) + 16 * (n / 8) + (n % 2)));
    end
    applyStimulus(1'b1);
    sampleNeg();
    checkOutput("t2_post_tvalid", 64'(M_AXIS_TVALID), 64'd0);

    // Backpressure on a 3-beat packet
    doReset();
    rdy_pat = 9'b1_1001_1111;
    acc_n = 0;
    rden_cnt = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    M_AXIS_TREADY = rdy_pat[0];
    pushPkt(1, 3, 32'h30);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) applyStimulus(rdy_pat[c]);
      sampleNeg();
      if (prev_stall) checkOutput("t3_stable", 64'(M_AXIS_TDATA), 64'(prev_data));
      if (SRC_RDEN[1]) rden_cnt++;
      observe();
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
    end
    checkOutput("t3_rden_count", 64'(rden_cnt), 64'd3);
    checkOutput("t3_beats",      64'(acc_n),    64'd3);
    for (int j = 0; j < 3; j++) checkOutput("t3_data", 64'(acc_data[j]), 64'h30 + 64'(j));

    // Owner runs empty mid-packet while source 2 waits
    doReset();
    M_AXIS_TREADY = 1'b1;
    acc_n = 0;
    pushBeat(0, 32'h40, '1, 1'b0);
    pushBeat(0, 32'h41, '1, 1'b0);
    pushPkt(2, 1, 32'h50);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) applyStimulus(1'b1);
      sampleNeg();
      checkOutput("t4_rden2", 64'(SRC_RDEN[2]), 64'd0);
      if (c >= 3) begin
        checkOutput("t4_gap_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        checkOutput("t4_gap_grant",  64'(GRANT),         64'b0001);
      end
      observe();
    end
    pushBeat(0, 32'h42, '1, 1'b0);
    pushBeat(0, 32'h43, '1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1);
      sampleNeg();
      if (GRANT[0]) checkOutput("t4_rden2_owned", 64'(SRC_RDEN[2]), 64'd0);
      observe();
    end
    checkOutput("t4_beats", 64'(acc_n), 64'd5);
    for (int j = 0; j < 4; j++) begin
      checkOutput("t4_data", 64'(acc_data[j]), 64'h40 + 64'(j));
      checkOutput("t4_tid",  64'(acc_tid[j]),  64'd0);
    end
    checkOutput("t4_data_src2", 64'(acc_data[4]), 64'h50);
    checkOutput("t4_tid_src2",  64'(acc_tid[4]),  64'd2);

    // Enable mask: source 1 never granted, clearing source 0 mid-packet
    doReset();
    M_AXIS_TREADY = 1'b1;
    SRC_ENABLE = 4'b1101;
    acc_n = 0;
    pushPkt(0, 3, 32'h60);
    pushPkt(1, 2, 32'h70);
    pushPkt(2, 2, 32'h80);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) applyStimulus(1'b1);
      if (c == 2) SRC_ENABLE = 4'b1100;
      sampleNeg();
      checkOutput("t5_grant1", 64'(GRANT[1]),    64'd0);
      checkOutput("t5_rden1",  64'(SRC_RDEN[1]), 64'd0);
      observe();
    end
    checkOutput("t5_beats", 64'(acc_n), 64'd5);
    checkOutput("t5_d0", 64'(acc_data[0]), 64'h60);
    checkOutput("t5_d2", 64'(acc_data[2]), 64'h62);
    checkOutput("t5_d3", 64'(acc_data[3]), 64'h80);
    checkOutput("t5_d4", 64'(acc_data[4]), 64'h81);
    SRC_ENABLE = '1;

    // Reset during the second beat, then sources 0 and 3 pending
    doReset();
    M_AXIS_TREADY = 1'b1;
    pushPkt(1, 3, 32'h90);
    sampleNeg();
    applyStimulus(1'b1);
    sampleNeg();
    checkOutput("t6_beat1", 64'(M_AXIS_TDATA), 64'h90);
    applyStimulus(1'b1);
    RST = 1'b1;
    sampleNeg();
    checkOutput("t6_beat2", 64'(M_AXIS_TDATA), 64'h91);
    applyStimulus(1'b1);
    RST = 1'b0;
    pushPkt(3, 2, 32'hA0);
    pushPkt(0, 2, 32'hB0);
    sampleNeg();
    checkOutput("t6_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("t6_rst_grant",  64'(GRANT),         64'd0);
    checkOutput("t6_rst_busy",   64'(BUSY),          64'd0);
    applyStimulus(1'b1);
    sampleNeg();
    checkOutput("t6_first_tid",  64'(M_AXIS_TID),   64'd0);
    checkOutput("t6_first_data", 64'(M_AXIS_TDATA), 64'hB0);

    // Random phase: beat-by-beat pushes, random ready and enable mask
    doReset();
    for (int i = 0; i < NUM_SRC; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus($urandom_range(0, 9) < 7);
      if (cyc % 64 == 0) SRC_ENABLE = ($urandom_range(0, 2) == 0) ? '1 : NUM_SRC'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        int s;
        s = $urandom_range(0, NUM_SRC - 1);
        if (tail[s] - head[s] < DEPTH - 2) begin
          if (rem[s] == 0) rem[s] = $urandom_range(1, 5);
          pushBeat(s, DW'($urandom), KW'($urandom), rem[s] == 1);
          rem[s]--;
        end
      end
    end
    SRC_ENABLE = '1;
    for (int i = 0; i < NUM_SRC; i++) begin
      while (rem[i] > 0) begin
        pushBeat(i, DW'($urandom), KW'($urandom), rem[i] == 1);
        rem[i]--;
      end
    end
    for (int cyc = 0; cyc < 600; cyc++) applyStimulus(1'b1);
    sampleNeg();
    checkOutput("drain_busy",   64'(BUSY),          64'd0);
    checkOutput("drain_tvalid", 64'(M_AXIS_TVALID), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
